// File: rtl/truth_table_sequencer.sv
// Truth-table sequencer: sweeps every input row of a selected 3- or 4-input
// combinational table, captures the returned Y bits, counts ones and compares
// the captured table against a golden pattern latched at start.
module truth_table_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [1:0]  sel,
    input  logic [15:0] expected,
    input  logic        y_in,
    output logic [3:0]  abcd,
    output logic [1:0]  table_sel,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic [4:0]  ones,
    output logic        mismatch,
    output logic [3:0]  err_idx,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SAMPLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic [3:0]  abcd_q, abcd_d;
    logic [1:0]  table_sel_q, table_sel_d;
    logic [15:0] exp_q, exp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] result_q, result_d;
    logic [4:0]  ones_q, ones_d;
    logic        mismatch_q, mismatch_d;
    logic [3:0]  err_idx_q, err_idx_d;

    // Odd sel values select the 3-input tables (8 rows, D tied low).
    logic        short_tbl;
    logic [3:0]  last_row;
    logic [3:0]  next_idx;
    logic [15:0] row_mask;
    logic [15:0] diff;

    assign short_tbl = table_sel_q[0];
    assign last_row  = short_tbl ? 4'd7 : 4'd15;
    assign next_idx  = idx_q + 4'd1;
    assign row_mask  = short_tbl ? 16'h00FF : 16'hFFFF;
    assign diff      = (result_q ^ exp_q) & row_mask;

    // Next-state and next-output computation; abort outranks every transition.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        abcd_d      = abcd_q;
        table_sel_d = table_sel_q;
        exp_d       = exp_q;
        result_d    = result_q;
        ones_d      = ones_q;
        mismatch_d  = mismatch_q;
        err_idx_d   = err_idx_q;
        done_d      = 1'b0;

        if (abort && (state_q != IDLE)) begin
            // Partial result and ones are kept; mismatch was cleared at start.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        table_sel_d = sel;
                        exp_d       = expected;
                        result_d    = 16'h0000;
                        ones_d      = 5'd0;
                        mismatch_d  = 1'b0;
                        err_idx_d   = 4'd0;
                        idx_d       = 4'd0;
                        abcd_d      = 4'd0;   // row 0 encodes to 0 for both widths
                        state_d     = DRIVE;
                    end
                end
                DRIVE: begin
                    // abcd is already stable; one cycle for the table to settle.
                    state_d = SAMPLE;
                end
                SAMPLE: begin
                    result_d[idx_q] = y_in;
                    if (y_in) begin
                        ones_d = ones_q + 5'd1;
                    end
                    if (idx_q == last_row) begin
                        state_d = CHECK;
                    end else begin
                        idx_d   = next_idx;
                        abcd_d  = short_tbl ? {next_idx[2:0], 1'b0} : next_idx;
                        state_d = DRIVE;
                    end
                end
                CHECK: begin
                    mismatch_d = |diff;
                    err_idx_d  = 4'd0;
                    for (int i = 15; i >= 0; i--) begin
                        if (diff[i]) begin
                            err_idx_d = 4'(i);
                        end
                    end
                    done_d  = 1'b1;
                    state_d = DONE;
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // Single state/output register bank with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= 4'd0;
            abcd_q      <= 4'd0;
            table_sel_q <= 2'd0;
            exp_q       <= 16'h0000;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= 16'h0000;
            ones_q      <= 5'd0;
            mismatch_q  <= 1'b0;
            err_idx_q   <= 4'd0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            abcd_q      <= abcd_d;
            table_sel_q <= table_sel_d;
            exp_q       <= exp_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            ones_q      <= ones_d;
            mismatch_q  <= mismatch_d;
            err_idx_q   <= err_idx_d;
        end
    end

    assign abcd      = abcd_q;
    assign table_sel = table_sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign ones      = ones_q;
    assign mismatch  = mismatch_q;
    assign err_idx   = err_idx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Bench for truth_table_sequencer: models the four tables (or a random LUT)
// as the combinational logic under test and checks every sweep cycle by cycle.
module tb_truth_table_sequencer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  sel;
    logic [15:0] expected;
    logic        y_in;
    logic [3:0]  abcd;
    logic [1:0]  table_sel;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [4:0]  ones;
    logic        mismatch;
    logic [3:0]  err_idx;
    logic [2:0]  dbg_state;

    truth_table_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .sel       (sel),
        .expected  (expected),
        .y_in      (y_in),
        .abcd      (abcd),
        .table_sel (table_sel),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .ones      (ones),
        .mismatch  (mismatch),
        .err_idx   (err_idx),
        .dbg_state (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- table models ----------------
    bit          lut_mode;
    logic [15:0] lut;

    function automatic logic tbl_fn(input logic [1:0] s, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (s)
            2'd0:    return (!b && !c && !d) || (a && !c) || (a && !d) || (a && !b);
            2'd1:    return !b || c;
            2'd2:    return (!b && !c && d) || b || (a && d);
            default: return (!a && !c) || b;
        endcase
    endfunction

    assign y_in = lut_mode ? lut[abcd] : tbl_fn(table_sel, abcd);

    function automatic int n_rows(input logic [1:0] s);
        return s[0] ? 8 : 16;
    endfunction

    function automatic logic [3:0] row_stim(input logic [1:0] s, input int r);
        logic [3:0] rv;
        rv = r[3:0];
        return s[0] ? {rv[2:0], 1'b0} : rv;
    endfunction

    function automatic logic [15:0] model_result(input logic [1:0] s, input bit lm,
                                                 input logic [15:0] lv);
        logic [15:0] m;
        logic [3:0]  v;
        m = 16'h0000;
        for (int r = 0; r < n_rows(s); r++) begin
            v = row_stim(s, r);
            m[r] = lm ? lv[v] : tbl_fn(s, v);
        end
        return m;
    endfunction

    // ---------------- scoreboard ----------------
    logic [15:0] exp_res_q[$];
    logic [4:0]  exp_ones_q[$];
    logic        exp_mm_q[$];
    logic [3:0]  exp_ei_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_abcd"},      abcd,      0);
        chk({tag, "_table_sel"}, table_sel, 0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
        chk({tag, "_result"},    result,    0);
        chk({tag, "_ones"},      ones,      0);
        chk({tag, "_mismatch"},  mismatch,  0);
        chk({tag, "_err_idx"},   err_idx,   0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
    endtask

    // ---------------- driver: one sweep, optionally aborted or reset ----------------
    task automatic run_sweep(input logic [1:0] s, input logic [15:0] e,
                             input int abort_at, input int rst_at, input bit abort_with_start);
        int          rows;
        int          done_c;
        int          end_c;
        int          sampled;
        int          ei;
        logic [15:0] m_res;
        logic [15:0] diff;
        logic [16:0] pm;

        rows   = n_rows(s);
        done_c = 2 * rows + 2;
        m_res  = model_result(s, lut_mode, lut);
        diff   = (m_res ^ e) & ((rows == 8) ? 16'h00FF : 16'hFFFF);
        ei = 0;
        for (int i = 0; i < 16; i++) begin
            if (diff[i]) begin
                ei = i;
                break;
            end
        end
        if (abort_at == 0 && rst_at == 0) begin
            exp_res_q.push_back(m_res);
            exp_ones_q.push_back(5'($countones(m_res)));
            exp_mm_q.push_back(diff != 16'h0000);
            exp_ei_q.push_back(4'(ei));
        end
        end_c = (abort_at != 0) ? abort_at + 1 : (rst_at != 0) ? rst_at + 1 : done_c + 1;

        sel = s; expected = e; start = 1'b1; abort = abort_with_start;
        @(posedge clk); #1;
        for (int c = 1; c <= end_c; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
            end
            if (rst_at != 0 && c == end_c) begin
                chk_all_zero("after_reset");
            end else if (abort_at != 0 && c == end_c) begin
                sampled = (abort_at - 1) / 2;
                if (sampled > rows) sampled = rows;
                pm = (17'd1 << sampled) - 17'd1;
                chk("abort_busy",     busy,     0);
                chk("abort_done",     done,     0);
                chk("abort_mismatch", mismatch, 0);
                chk("abort_result",   result,   m_res & pm[15:0]);
                chk("abort_ones",     ones,     $countones(m_res & pm[15:0]));
            end else begin
                chk("busy",      busy,      (c <= done_c) ? 1 : 0);
                chk("done",      done,      (c == done_c) ? 1 : 0);
                chk("table_sel", table_sel, s);
                if (c <= 2 * rows) begin
                    chk("abcd", abcd, row_stim(s, (c - 1) / 2));
                end
                if (c == done_c) begin
                    if (exp_res_q.size() == 0) begin
                        chk("sb_empty", 1, 0);
                    end else begin
                        chk("result",   result,   exp_res_q.pop_front());
                        chk("ones",     ones,     exp_ones_q.pop_front());
                        chk("mismatch", mismatch, exp_mm_q.pop_front());
                        chk("err_idx",  err_idx,  exp_ei_q.pop_front());
                    end
                end
                if (c == done_c + 1) begin
                    chk("hold_result", result, m_res);
                end
            end
            // Inputs for the next edge: noise on start/sel/expected while busy.
            if (c < end_c) begin
                start    = 1'($urandom_range(0, 1));
                sel      = 2'($urandom);
                expected = 16'($urandom);
                abort    = 1'b0;
            end
            if (c == abort_at) abort = 1'b1;
            if (c == rst_at) begin
                rst_n = 1'b0; start = 1'b1; abort = 1'b1;
            end
            if (c == end_c) begin
                start = 1'b0; abort = 1'b0; rst_n = 1'b1;
            end
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [1:0]  s;
        logic [15:0] m;
        logic [15:0] flip;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel = 2'd0; expected = 16'h0000;
        lut_mode = 1'b0; lut = 16'h0000;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("reset");
        rst_n = 1'b1; start = 1'b0; abort = 1'b0;
        idle_cycle();

        run_sweep(2'd0, 16'h7F01, 0, 0, 0);
        chk("t1_result", result, 16'h7F01);
        chk("t1_ones", ones, 8);
        chk("t1_mismatch", mismatch, 0);
        idle_cycle();

        run_sweep(2'd1, 16'h00BB, 0, 0, 1);
        chk("t2_result", result, 16'h00BB);
        chk("t2_ones", ones, 6);
        chk("t2_mismatch", mismatch, 0);
        idle_cycle();

        run_sweep(2'd2, 16'hFAF2, 0, 0, 0);
        chk("t3_result", result, 16'hFAF2);
        chk("t3_ones", ones, 11);
        chk("t3_mismatch", mismatch, 0);
        idle_cycle();

        run_sweep(2'd3, 16'h00CC, 0, 0, 0);
        chk("t4_result", result, 16'h00CD);
        chk("t4_ones", ones, 5);
        chk("t4_mismatch", mismatch, 1);
        chk("t4_err_idx", err_idx, 0);
        idle_cycle();

        run_sweep(2'd0, 16'h7F01, 10, 0, 0);
        idle_cycle();
        run_sweep(2'd0, 16'h7F01, 0, 0, 0);
        idle_cycle();

        run_sweep(2'd0, 16'h7F01, 0, 20, 0);
        idle_cycle();

        for (int n = 0; n < 14; n++) begin
            s        = 2'($urandom);
            lut_mode = 1'($urandom_range(0, 1));
            lut      = 16'($urandom);
            m        = model_result(s, lut_mode, lut);
            case ($urandom_range(0, 2))
                0:       flip = 16'h0000;
                1:       flip = 16'h0001 << $urandom_range(0, 15);
                default: flip = 16'($urandom);
            endcase
            if (n == 12) run_sweep(s, m ^ flip, int'($urandom_range(1, 14)), 0, 0);
            else         run_sweep(s, m ^ flip, 0, 0, 1'($urandom_range(0, 1)));
            idle_cycle();
        end

        chk("sb_drained", exp_res_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
